// File: rtl/approx_mult_error_sweeper.sv
// approx_mult_error_sweeper: drives every (a,b) operand pair into an external
// approximate multiplier and accumulates error count, summed/max error distance,
// summed relative error and mean relative error distance on-chip.
module approx_mult_error_sweeper #(
    parameter int WIDTH   = 4,
    parameter int FRAC    = 8,
    parameter int DUT_LAT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH-1:0]          op_a,
    output logic [WIDTH-1:0]          op_b,
    input  logic [2*WIDTH-1:0]        approx_in,
    output logic [2*WIDTH:0]          err_count,
    output logic [4*WIDTH:0]          sed,
    output logic [2*WIDTH-1:0]        max_ed,
    output logic [WIDTH-1:0]          max_ed_a,
    output logic [WIDTH-1:0]          max_ed_b,
    output logic [4*WIDTH+FRAC:0]     sum_re,
    output logic [2*WIDTH+FRAC:0]     mred
);
    localparam int PW   = 2 * WIDTH;          // product width
    localparam int DW   = PW + FRAC;          // dividend / quotient width
    localparam int EW   = PW + 1;             // err_count width
    localparam int SW   = 2 * PW + 1;         // sed width
    localparam int RW   = 2 * PW + FRAC + 1;  // sum_re width
    localparam int CMAX = (DW > DUT_LAT) ? DW : DUT_LAT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [PW-1:0] LAST = '1;

    typedef enum logic [2:0] {IDLE, SETUP, SAMPLE, DIV, ACC} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   approx_q;
    logic [PW-1:0]   exact_q;
    logic [PW-1:0]   ed_q;
    logic [DW-1:0]   dq;        // dividend shifts out the top, quotient bits shift in at the bottom
    logic [PW-1:0]   rem;

    logic [PW-1:0]   exact_w;
    logic [PW-1:0]   ed_w;
    logic            skip_div;
    logic [PW:0]     trial;
    logic            fits;
    logic [PW-1:0]   rem_sub;
    logic            setup_end;
    logic            div_end;

    // operands come straight from the pair index register, so they move only when idx does
    assign op_a = idx[PW-1:WIDTH];
    assign op_b = idx[WIDTH-1:0];
    assign mred = sum_re[RW-1:PW];

    assign exact_w   = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
    assign ed_w      = (approx_q >= exact_w) ? (approx_q - exact_w) : (exact_w - approx_q);
    assign skip_div  = (exact_w == '0) || (ed_w == '0);
    // remainder stays below exact_q, so the low PW bits of the difference are exact
    assign trial     = {rem, dq[DW-1]};
    assign fits      = trial >= {1'b0, exact_q};
    assign rem_sub   = trial[PW-1:0] - exact_q;
    assign setup_end = (cnt == CW'(DUT_LAT));
    assign div_end   = (cnt == CW'(DW - 1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   if (setup_end) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = skip_div ? ACC : DIV;
            DIV:     if (div_end) state_nxt = ACC;
            ACC:     state_nxt = (idx == LAST) ? IDLE : SETUP;
            default: state_nxt = IDLE;
        endcase
    end

    // sweep datapath: index, DUT capture, serial divider, accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            approx_q  <= '0;
            exact_q   <= '0;
            ed_q      <= '0;
            dq        <= '0;
            rem       <= '0;
            err_count <= '0;
            sed       <= '0;
            max_ed    <= '0;
            max_ed_a  <= '0;
            max_ed_b  <= '0;
            sum_re    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    idx       <= '0;
                    cnt       <= '0;
                    err_count <= '0;
                    sed       <= '0;
                    max_ed    <= '0;
                    max_ed_a  <= '0;
                    max_ed_b  <= '0;
                    sum_re    <= '0;
                end
                SETUP: begin
                    cnt <= cnt + 1'b1;
                    // DUT output for the current operands is valid on this edge
                    if (setup_end) approx_q <= approx_in;
                end
                SAMPLE: begin
                    ed_q    <= ed_w;
                    exact_q <= exact_w;
                    rem     <= '0;
                    cnt     <= '0;
                    dq      <= skip_div ? '0 : {ed_w, {FRAC{1'b0}}};
                end
                DIV: begin
                    cnt <= cnt + 1'b1;
                    rem <= fits ? rem_sub : trial[PW-1:0];
                    dq  <= {dq[DW-2:0], fits};
                end
                ACC: begin
                    err_count <= err_count + EW'(ed_q != '0);
                    sed       <= sed + SW'(ed_q);
                    sum_re    <= sum_re + RW'(dq);
                    if (ed_q > max_ed) begin
                        max_ed   <= ed_q;
                        max_ed_a <= op_a;
                        max_ed_b <= op_b;
                    end
                    cnt <= '0;
                    if (idx == LAST) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_mult_error_sweeper.sv
// Bench for approx_mult_error_sweeper: a table-driven approximate multiplier with
// registered latency feeds the sweeper; a reference model computes each sweep's
// metrics and cycle count into a scoreboard checked when done rises.
module tb_approx_mult_error_sweeper;
    localparam int W   = 2;
    localparam int FR  = 8;
    localparam int LAT = 2;
    localparam int PW  = 2 * W;
    localparam int N   = 1 << PW;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start = 1'b0;
    logic               busy, done;
    logic [W-1:0]       op_a, op_b;
    logic [PW-1:0]      approx_in;
    logic [PW:0]        err_count;
    logic [2*PW:0]      sed;
    logic [PW-1:0]      max_ed;
    logic [W-1:0]       max_ed_a, max_ed_b;
    logic [2*PW+FR:0]   sum_re;
    logic [PW+FR:0]     mred;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    approx_mult_error_sweeper #(.WIDTH(W), .FRAC(FR), .DUT_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .op_a(op_a), .op_b(op_b), .approx_in(approx_in),
        .err_count(err_count), .sed(sed), .max_ed(max_ed),
        .max_ed_a(max_ed_a), .max_ed_b(max_ed_b), .sum_re(sum_re), .mred(mred)
    );

    // approximate multiplier under characterisation: lookup table behind LAT registers
    logic [PW-1:0] tbl [N];
    logic [PW-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= tbl[{op_a, op_b}];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign approx_in = pipe[LAT-1];

    typedef struct {
        longint err, sed, maxed, ma, mb, sre, mred, cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // fill the multiplier table; mode 0 exact, 1 zero, 2 +1 saturated, 3 random errors
    task automatic build(input int mode);
        for (int i = 0; i < N; i++) begin
            int p;
            p = (i >> W) * (i % (1 << W));
            case (mode)
                0: tbl[i] = PW'(p);
                1: tbl[i] = '0;
                2: tbl[i] = (p + 1 > N - 1) ? PW'(N - 1) : PW'(p + 1);
                default: tbl[i] = ($urandom_range(0, 1) == 1) ? PW'(p) : PW'($urandom_range(0, N - 1));
            endcase
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        e = '{default: 0};
        for (int i = 0; i < N; i++) begin
            longint a, b, p, ap, ed;
            a  = i >> W;
            b  = i % (1 << W);
            p  = a * b;
            ap = longint'(tbl[i]);
            ed = (ap > p) ? ap - p : p - ap;
            if (ed != 0) e.err++;
            e.sed += ed;
            if (ed > e.maxed) begin
                e.maxed = ed;
                e.ma    = a;
                e.mb    = b;
            end
            e.cyc += 3 + LAT;
            if (p != 0 && ed != 0) begin
                e.sre += (ed * (longint'(1) << FR)) / p;
                e.cyc += PW + FR;
            end
        end
        e.mred = e.sre / N;
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_op"}, 64'({op_a, op_b}), 0);
        check({tag, "_err"}, 64'(err_count), 0);
        check({tag, "_sed"}, 64'(sed), 0);
        check({tag, "_maxed"}, 64'({max_ed, max_ed_a, max_ed_b}), 0);
        check({tag, "_sre"}, 64'(sum_re), 0);
        check({tag, "_mred"}, 64'(mred), 0);
    endtask

    // one sweep: optional start poke mid-sweep, optional reset abort at cycle abort_at
    task automatic sweep(input int mode, input int poke_at, input int abort_at);
        exp_t e;
        build(mode);
        e = model();
        if (abort_at == 0) sb.push_back(e);
        @(negedge clk) start = 1'b1;
        for (int k = 1; k <= e.cyc + 3; k++) begin
            @(negedge clk);
            // a pulse on the final busy cycle coincides with done rising and must be ignored
            start = (k == poke_at) || (k == e.cyc);
            if (k == abort_at) begin
                start = 1'b0;
                rst_n = 1'b0;
                #1 check_zero("abort");
                @(negedge clk);
                @(negedge clk) rst_n = 1'b1;
                return;
            end
            if (k == e.cyc + 3) begin
                check("busy_after_done", 64'(busy), 0);
                check("done_sticky", 64'(done), 1);
            end
        end
    endtask

    // monitor: compare results whenever done rises, with the busy-cycle count of that sweep
    int   bcnt   = 0;
    logic done_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bcnt   = 0;
            done_q = 1'b0;
        end else begin
            if (busy) bcnt++;
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done with no sweep pending, expected none");
                end else begin
                    e = sb.pop_front();
                    check("err_count", 64'(err_count), e.err);
                    check("sed", 64'(sed), e.sed);
                    check("max_ed", 64'(max_ed), e.maxed);
                    check("max_ed_a", 64'(max_ed_a), e.ma);
                    check("max_ed_b", 64'(max_ed_b), e.mb);
                    check("sum_re", 64'(sum_re), e.sre);
                    check("mred", 64'(mred), e.mred);
                    check("busy_cycles", 64'(bcnt), e.cyc);
                end
                bcnt = 0;
            end
            done_q = done;
        end
    end

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) tbl[i] = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        sweep(0, 0, 0);     // exact multiplier: all metrics zero
        sweep(1, 10, 0);    // always-zero product, stray start at cycle 10
        sweep(1, 0, 40);    // reset mid-sweep
        sweep(1, 0, 0);     // re-run after abort
        sweep(2, 0, 0);     // off-by-one everywhere, first max at (0,0)
        for (int r = 0; r < 4; r++) sweep(3, $urandom_range(2, 60), 0);
        repeat (3) @(negedge clk);
        check("sb_drain", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
